// File: rtl/uart_serial_port.sv
// UART front end for the processor serial port: 2-flop RX synchronizer, RX/TX 8N1 state
// machines, one show-ahead FIFO per direction, and sticky RX error flags.

module uart_serial_port_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);
  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNTW-1:0]  count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNTW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

module uart_serial_port #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       uart_rx_in,
  output logic       uart_tx_out,
  output logic [7:0] rx_data_out,
  output logic       rx_valid_out,
  input  logic       rx_rden_in,
  input  logic [7:0] tx_data_in,
  input  logic       tx_wren_in,
  output logic       tx_ready_out,
  input  logic       err_clear_in,
  output logic       rx_overrun_out,
  output logic       rx_frame_err_out
);
  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  // ---------------- RX synchronizer ----------------
  logic rx_meta;
  logic rx_sync;

  always_ff @(posedge clock) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= uart_rx_in;
      rx_sync <= rx_meta;
    end
  end

  // ---------------- RX FIFO ----------------
  logic       rx_push;
  logic       rx_empty;
  logic       rx_full;
  logic [7:0] rx_shift;

  uart_serial_port_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_rx_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (rx_push),
    .push_data(rx_shift),
    .pop      (rx_rden_in),
    .head     (rx_data_out),
    .empty    (rx_empty),
    .full     (rx_full)
  );

  assign rx_valid_out = !rx_empty;

  // ---------------- RX FSM ----------------
  rx_state_t     rx_state, rx_state_n;
  logic [CW-1:0] rx_cnt, rx_cnt_n;
  logic [2:0]    rx_bit, rx_bit_n;
  logic [7:0]    rx_shift_n;
  logic          rx_armed, rx_armed_n;
  logic          overrun_set;
  logic          frame_set;

  always_ff @(posedge clock) begin
    if (!reset) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_armed <= 1'b0;
    end else begin
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_bit   <= rx_bit_n;
      rx_shift <= rx_shift_n;
      rx_armed <= rx_armed_n;
    end
  end

  // IDLE notices the low synchronized level one edge after it appears, so START begins
  // counting at 1 to keep every sample point referenced to the synchronized falling edge.
  always_comb begin
    rx_state_n  = rx_state;
    rx_cnt_n    = rx_cnt + CW'(1);
    rx_bit_n    = rx_bit;
    rx_shift_n  = rx_shift;
    rx_armed_n  = rx_armed;
    rx_push     = 1'b0;
    overrun_set = 1'b0;
    frame_set   = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        rx_cnt_n = CW'(1);
        if (rx_sync) begin
          rx_armed_n = 1'b1;
        end else if (rx_armed) begin
          rx_state_n = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt == HALF_M1) begin
          rx_cnt_n = '0;
          if (rx_sync) begin
            rx_state_n = RX_IDLE;
          end else begin
            rx_state_n = RX_DATA;
            rx_bit_n   = '0;
          end
        end
      end
      RX_DATA: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_n   = '0;
          rx_shift_n = {rx_sync, rx_shift[7:1]};
          rx_bit_n   = rx_bit + 3'd1;
          if (rx_bit == 3'd7) rx_state_n = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_n   = '0;
          rx_state_n = RX_IDLE;
          rx_armed_n = 1'b0;
          if (!rx_sync)     frame_set   = 1'b1;
          else if (rx_full) overrun_set = 1'b1;
          else              rx_push     = 1'b1;
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  // ---------------- Sticky error flags (set beats clear) ----------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      rx_overrun_out   <= 1'b0;
      rx_frame_err_out <= 1'b0;
    end else begin
      rx_overrun_out   <= overrun_set | (rx_overrun_out & ~err_clear_in);
      rx_frame_err_out <= frame_set | (rx_frame_err_out & ~err_clear_in);
    end
  end

  // ---------------- TX FIFO ----------------
  logic       tx_pop;
  logic       tx_empty;
  logic       tx_full;
  logic [7:0] tx_head;

  uart_serial_port_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_tx_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (tx_wren_in),
    .push_data(tx_data_in),
    .pop      (tx_pop),
    .head     (tx_head),
    .empty    (tx_empty),
    .full     (tx_full)
  );

  assign tx_ready_out = !tx_full;

  // ---------------- TX FSM ----------------
  tx_state_t     tx_state, tx_state_n;
  logic [CW-1:0] tx_cnt, tx_cnt_n;
  logic [2:0]    tx_bit, tx_bit_n;
  logic [7:0]    tx_shift, tx_shift_n;
  logic          tx_line, tx_line_n;

  always_ff @(posedge clock) begin
    if (!reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_line  <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      tx_shift <= tx_shift_n;
      tx_line  <= tx_line_n;
    end
  end

  assign uart_tx_out = tx_line;

  // The line register is loaded with the level of the state being entered, so each
  // bit is on the pin for exactly CLKS_PER_BIT cycles with no output glitches.
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt + CW'(1);
    tx_bit_n   = tx_bit;
    tx_shift_n = tx_shift;
    tx_line_n  = tx_line;
    tx_pop     = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        tx_cnt_n  = '0;
        tx_line_n = 1'b1;
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_shift_n = tx_head;
          tx_line_n  = 1'b0;
          tx_state_n = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_n   = '0;
          tx_bit_n   = '0;
          tx_line_n  = tx_shift[0];
          tx_state_n = TX_DATA;
        end
      end
      TX_DATA: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_n   = '0;
          tx_bit_n   = tx_bit + 3'd1;
          tx_shift_n = {1'b1, tx_shift[7:1]};
          if (tx_bit == 3'd7) begin
            tx_line_n  = 1'b1;
            tx_state_n = TX_STOP;
          end else begin
            tx_line_n = tx_shift[1];
          end
        end
      end
      TX_STOP: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_n = '0;
          if (!tx_empty) begin
            tx_pop     = 1'b1;
            tx_shift_n = tx_head;
            tx_line_n  = 1'b0;
            tx_state_n = TX_START;
          end else begin
            tx_line_n  = 1'b1;
            tx_state_n = TX_IDLE;
          end
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_serial_port.sv
// Scoreboard bench for uart_serial_port: queues of expected bytes per direction, a line
// decoder for TX frames and a pop monitor for RX data, with directed and random stimulus.

module tb_uart_serial_port;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       uart_rx_in = 1'b1;
  logic       uart_tx_out;
  logic [7:0] rx_data_out;
  logic       rx_valid_out;
  logic       rx_rden_in = 1'b0;
  logic [7:0] tx_data_in = '0;
  logic       tx_wren_in = 1'b0;
  logic       tx_ready_out;
  logic       err_clear_in = 1'b0;
  logic       rx_overrun_out;
  logic       rx_frame_err_out;

  uart_serial_port #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .uart_rx_in      (uart_rx_in),
    .uart_tx_out     (uart_tx_out),
    .rx_data_out     (rx_data_out),
    .rx_valid_out    (rx_valid_out),
    .rx_rden_in      (rx_rden_in),
    .tx_data_in      (tx_data_in),
    .tx_wren_in      (tx_wren_in),
    .tx_ready_out    (tx_ready_out),
    .err_clear_in    (err_clear_in),
    .rx_overrun_out  (rx_overrun_out),
    .rx_frame_err_out(rx_frame_err_out)
  );

  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int          checks   = 0;
  int          failures = 0;
  logic [7:0]  rx_exp[$];
  logic [7:0]  tx_exp[$];
  int unsigned tx_starts[$];
  bit          mon_en   = 1'b0;
  bit          mon_busy = 1'b0;
  bit          exp_ovr  = 1'b0;
  bit          exp_ferr = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Drive one 8N1 frame; the reference model decides push / overrun / frame error.
  task automatic send_rx(input logic [7:0] d, input bit stop, input bit pop_at_stop);
    logic [9:0] fr;
    fr = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx_in = fr[i];
      if (i == 9) begin
        tick(CPB - 1);
        check("rx_valid_pre_stop", rx_valid_out, rx_exp.size() != 0);
        if (pop_at_stop) rx_rden_in = 1'b1;
        tick(1);
        rx_rden_in = 1'b0;
      end else begin
        tick(CPB);
      end
    end
    uart_rx_in = 1'b1;
    if (!stop) exp_ferr = 1'b1;
    else if (rx_exp.size() >= DEPTH) exp_ovr = 1'b1;
    else rx_exp.push_back(d);
    check("rx_valid_post_stop", rx_valid_out, rx_exp.size() != 0);
    check("rx_frame_err", rx_frame_err_out, exp_ferr);
    check("rx_overrun", rx_overrun_out, exp_ovr);
  endtask

  task automatic rx_pop();
    check("rx_valid_at_pop", rx_valid_out, rx_exp.size() != 0);
    rx_rden_in = 1'b1;
    tick(1);
    rx_rden_in = 1'b0;
  endtask

  task automatic err_clear();
    err_clear_in = 1'b1;
    tick(1);
    err_clear_in = 1'b0;
    exp_ovr  = 1'b0;
    exp_ferr = 1'b0;
    check("flag_ovr_cleared", rx_overrun_out, 1'b0);
    check("flag_ferr_cleared", rx_frame_err_out, 1'b0);
  endtask

  task automatic tx_write(input logic [7:0] d, input bit accepted);
    tx_data_in = d;
    tx_wren_in = 1'b1;
    if (accepted) tx_exp.push_back(d);
    tick(1);
    tx_wren_in = 1'b0;
  endtask

  task automatic wait_tx_idle();
    int n;
    n = 0;
    while ((tx_exp.size() != 0 || mon_busy) && n < 3000) begin
      tick(1);
      n++;
    end
    if (n >= 3000) begin
      checks++;
      failures++;
      $display("FAIL tx_drain_timeout pending=%0d expected=0", tx_exp.size());
    end
    tick(CPB);
  endtask

  // RX monitor: every accepted pop must present the oldest expected byte.
  always @(negedge clock) begin
    if (rx_rden_in && rx_valid_out) begin
      if (rx_exp.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rx_unexpected_byte actual=%0h expected=none", rx_data_out);
      end else begin
        check("rx_data", rx_data_out, rx_exp.pop_front());
      end
    end
  end

  // TX monitor: decode frames at bit centres and compare against the expected queue.
  initial begin
    logic       prev;
    logic [7:0] d;
    prev = 1'b1;
    forever begin
      @(negedge clock);
      if (mon_en && prev && !uart_tx_out) begin
        mon_busy = 1'b1;
        tx_starts.push_back(cyc);
        repeat (CPB / 2) @(negedge clock);
        check("tx_start_bit", uart_tx_out, 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clock);
          d[i] = uart_tx_out;
        end
        repeat (CPB) @(negedge clock);
        check("tx_stop_bit", uart_tx_out, 1'b1);
        if (tx_exp.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL tx_unexpected_frame actual=%0h expected=none", d);
        end else begin
          check("tx_data", d, tx_exp.pop_front());
        end
        repeat (CPB - CPB / 2 - 1) @(negedge clock);
        mon_busy = 1'b0;
      end
      prev = uart_tx_out;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout cycles=%0d expected=finish", cyc);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned wc;
    int          lows;
    logic [7:0]  d;
    bit          stop;

    // Power-on reset
    reset = 1'b0;
    tick(3);
    check("reset_tx_line", uart_tx_out, 1'b1);
    check("reset_rx_valid", rx_valid_out, 1'b0);
    check("reset_tx_ready", tx_ready_out, 1'b1);
    check("reset_flags", {rx_overrun_out, rx_frame_err_out}, 2'b00);
    reset = 1'b1;
    tick(2);

    // Reset in the middle of a TX frame, with RX state and a flag set
    send_rx(8'h11, 1'b1, 1'b0);
    send_rx(8'h22, 1'b0, 1'b0);
    tx_write(8'h5A, 1'b0);
    tick(8);
    check("tx_frame_active", uart_tx_out, 1'b0);
    reset = 1'b0;
    tick(3);
    rx_exp.delete();
    exp_ovr  = 1'b0;
    exp_ferr = 1'b0;
    check("midreset_tx_line", uart_tx_out, 1'b1);
    check("midreset_rx_valid", rx_valid_out, 1'b0);
    check("midreset_tx_ready", tx_ready_out, 1'b1);
    check("midreset_flags", {rx_overrun_out, rx_frame_err_out}, 2'b00);
    reset = 1'b1;
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      tick(1);
      if (!uart_tx_out) lows++;
    end
    check("no_residual_frame", lows, 0);
    mon_en = 1'b1;

    // RX basic, back-to-back frames
    send_rx(8'h55, 1'b1, 1'b0);
    send_rx(8'hA3, 1'b1, 1'b0);
    rx_pop();
    rx_pop();
    check("rx_empty_after_pops", rx_valid_out, 1'b0);

    // RX errors
    uart_rx_in = 1'b0;
    tick(1);
    uart_rx_in = 1'b1;
    tick(20);
    check("glitch_no_push", rx_valid_out, 1'b0);
    send_rx(8'h3C, 1'b0, 1'b0);
    tick(2 * CPB);
    for (int i = 0; i < 5; i++) send_rx(8'h80 + 8'(i), 1'b1, 1'b0);
    check("overrun_set", rx_overrun_out, 1'b1);
    err_clear();
    for (int i = 0; i < 5; i++) rx_pop();

    // RX push and pop in the same cycle
    send_rx(8'hC1, 1'b1, 1'b0);
    send_rx(8'hC2, 1'b1, 1'b0);
    send_rx(8'hC3, 1'b1, 1'b1);
    rx_pop();
    rx_pop();
    check("rx_empty_after_simul", rx_valid_out, 1'b0);

    // TX back-to-back
    tx_starts.delete();
    wc = cyc;
    tx_write(8'h41, 1'b1);
    check("tx_line_high_1_edge", uart_tx_out, 1'b1);
    tx_write(8'h42, 1'b1);
    check("tx_line_low_2_edges", uart_tx_out, 1'b0);
    wait_tx_idle();
    check("tx_frame_count", tx_starts.size(), 2);
    if (tx_starts.size() == 2) begin
      check("tx_first_start", tx_starts[0], wc + 2);
      check("tx_contiguous", tx_starts[1], wc + 2 + 10 * CPB);
    end
    check("tx_idle_high", uart_tx_out, 1'b1);

    // TX full: the first byte leaves the FIFO at once, so DEPTH+1 writes fit
    for (int i = 0; i < DEPTH + 2; i++) begin
      check("tx_ready_burst", tx_ready_out, i <= DEPTH);
      tx_write(8'(i + 1), i <= DEPTH);
    end
    check("tx_ready_full", tx_ready_out, 1'b0);
    wait_tx_idle();
    check("tx_ready_drained", tx_ready_out, 1'b1);

    // Random traffic on both directions concurrently
    fork
      begin
        for (int f = 0; f < 12; f++) begin
          d    = 8'($urandom);
          stop = ($urandom_range(0, 7) != 0);
          send_rx(d, stop, 1'b0);
          if (!stop) tick(2 * CPB);
          tick($urandom_range(0, 5));
          repeat ($urandom_range(0, 2)) rx_pop();
          if ($urandom_range(0, 3) == 0) err_clear();
        end
      end
      begin
        for (int b = 0; b < 6; b++) begin
          for (int k = 0; k < $urandom_range(1, DEPTH); k++) begin
            check("tx_ready_rand", tx_ready_out, 1'b1);
            tx_write(8'($urandom), 1'b1);
            tick($urandom_range(0, 3));
          end
          wait_tx_idle();
        end
      end
    join
    while (rx_exp.size() != 0) rx_pop();
    check("rx_final_empty", rx_valid_out, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
